// File: rtl/eq_scale_sched.sv
// Time-multiplexed equalizer band-gain and volume scheduler: one shared signed
// 16x13 multiplier sequences ten band scalings plus two volume scalings per set.
module eq_scale_sched #(
  parameter int GAIN_SHIFT = 10,
  parameter int IDLE_TO    = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        filt_vld,
  input  logic [79:0] band_L,
  input  logic [79:0] band_R,
  input  logic [11:0] POT_LP,
  input  logic [11:0] POT_B1,
  input  logic [11:0] POT_B2,
  input  logic [11:0] POT_B3,
  input  logic [11:0] POT_HP,
  input  logic [11:0] POT_VOL,
  output logic [15:0] lft_out,
  output logic [15:0] rht_out,
  output logic        out_vld,
  output logic        busy,
  output logic        overrun,
  output logic        AMP_ON
);
  localparam int CW = $clog2(IDLE_TO + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TO);
  localparam logic signed [28:0] SMAX = 29'sd32767;
  localparam logic signed [28:0] SMIN = -29'sd32768;

  typedef enum logic [1:0] {IDLE, BAND, VOL, DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0][15:0] bl_q, bl_d, br_q, br_d;
  logic [5:0][11:0] pot_q, pot_d;
  logic signed [18:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0] stg_l_q, stg_l_d, stg_r_q, stg_r_d;
  logic [15:0] lft_q, lft_d, rht_q, rht_d;
  logic vld_q, vld_d, ovr_q, ovr_d, amp_q, amp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0] bi;
  logic signed [15:0] mul_a, scaled;
  logic signed [12:0] mul_b;
  logic signed [28:0] prod, shifted;
  logic accept;

  function automatic logic signed [15:0] sat16(input logic signed [28:0] x);
    if (x > SMAX)      return 16'sh7fff;
    else if (x < SMIN) return 16'sh8000;
    else               return x[15:0];
  endfunction

  // Shared multiplier operand select: band samples in BAND, clamped accumulators in VOL.
  always_comb begin
    bi    = (idx_q < 4'd5) ? idx_q[2:0] : 3'(idx_q - 4'd5);
    mul_a = '0;
    mul_b = '0;
    if (state_q == BAND) begin
      mul_a = (idx_q < 4'd5) ? bl_q[bi] : br_q[bi];
      mul_b = {1'b0, pot_q[bi]};
    end else if (state_q == VOL) begin
      mul_a = idx_q[0] ? sat16({{10{acc_r_q[18]}}, acc_r_q})
                       : sat16({{10{acc_l_q[18]}}, acc_l_q});
      mul_b = {1'b0, pot_q[5]};
    end
    prod    = mul_a * mul_b;
    shifted = prod >>> GAIN_SHIFT;
    scaled  = sat16(shifted);
  end

  assign accept = (state_q == IDLE) && filt_vld;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bl_d    = bl_q;
    br_d    = br_q;
    pot_d   = pot_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    stg_l_d = stg_l_q;
    stg_r_d = stg_r_q;
    lft_d   = lft_q;
    rht_d   = rht_q;
    vld_d   = 1'b0;
    ovr_d   = ovr_q | (filt_vld && state_q != IDLE);
    case (state_q)
      IDLE: if (filt_vld) begin
        state_d = BAND;
        idx_d   = '0;
        bl_d    = band_L;
        br_d    = band_R;
        pot_d   = {POT_VOL, POT_HP, POT_B3, POT_B2, POT_B1, POT_LP};
        acc_l_d = '0;
        acc_r_d = '0;
      end
      BAND: begin
        if (idx_q < 4'd5) acc_l_d = acc_l_q + {{3{scaled[15]}}, scaled};
        else              acc_r_d = acc_r_q + {{3{scaled[15]}}, scaled};
        if (idx_q == 4'd9) begin
          state_d = VOL;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      VOL: begin
        if (!idx_q[0]) begin
          stg_l_d = scaled;
          idx_d   = 4'd1;
        end else begin
          stg_r_d = scaled;
          state_d = DONE;
        end
      end
      DONE: begin
        lft_d   = stg_l_q;
        rht_d   = stg_r_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = accept ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    // Clear on the same edge the counter reaches the timeout so AMP_ON drops exactly then.
    amp_d = vld_d ? 1'b1 : ((cnt_d == CNT_MAX) ? 1'b0 : amp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bl_q    <= '0;
      br_q    <= '0;
      pot_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      stg_l_q <= '0;
      stg_r_q <= '0;
      lft_q   <= '0;
      rht_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      amp_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bl_q    <= bl_d;
      br_q    <= br_d;
      pot_q   <= pot_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      stg_l_q <= stg_l_d;
      stg_r_q <= stg_r_d;
      lft_q   <= lft_d;
      rht_q   <= rht_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      amp_q   <= amp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lft_out = lft_q;
  assign rht_out = rht_q;
  assign out_vld = vld_q;
  assign busy    = (state_q != IDLE);
  assign overrun = ovr_q;
  assign AMP_ON  = amp_q;
endmodule

// File: tb/tb_eq_scale_sched.sv
// Scoreboard bench for eq_scale_sched: directed sets push expected stereo results,
// a negedge monitor pops and checks them on every out_vld.
module tb_eq_scale_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        filt_vld = 1'b0;
  logic [79:0] band_L = '0, band_R = '0;
  logic [11:0] POT_LP = '0, POT_B1 = '0, POT_B2 = '0, POT_B3 = '0, POT_HP = '0, POT_VOL = '0;
  logic [15:0] lft_out, rht_out;
  logic        out_vld, busy, overrun, AMP_ON;

  eq_scale_sched #(.GAIN_SHIFT(10), .IDLE_TO(32)) dut (
    .clk(clk), .rst(rst), .filt_vld(filt_vld), .band_L(band_L), .band_R(band_R),
    .POT_LP(POT_LP), .POT_B1(POT_B1), .POT_B2(POT_B2), .POT_B3(POT_B3), .POT_HP(POT_HP),
    .POT_VOL(POT_VOL), .lft_out(lft_out), .rht_out(rht_out), .out_vld(out_vld),
    .busy(busy), .overrun(overrun), .AMP_ON(AMP_ON)
  );

  always #5 clk = ~clk;

  typedef struct { int l; int r; int cap; } exp_t;
  exp_t sb[$];
  int ntest = 0, nfail = 0, cyc = 0, cap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_vld", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lft_out", int'($signed(lft_out)), e.l);
        chk("rht_out", int'($signed(rht_out)), e.r);
        chk("latency", cyc - e.cap, 13);
      end
    end
  end

  function automatic logic [79:0] pk(input int lp, b1, b2, b3, hp);
    logic [15:0] a0, a1, a2, a3, a4;
    a0 = 16'(lp); a1 = 16'(b1); a2 = 16'(b2); a3 = 16'(b3); a4 = 16'(hp);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic send(input logic [79:0] l, r, input int plp, pb1, pb2, pb3, php, pv,
                      input bit push, input int el, er);
    exp_t e;
    @(negedge clk);
    band_L = l; band_R = r;
    POT_LP = 12'(plp); POT_B1 = 12'(pb1); POT_B2 = 12'(pb2);
    POT_B3 = 12'(pb3); POT_HP = 12'(php); POT_VOL = 12'(pv);
    filt_vld = 1'b1;
    @(posedge clk);
    #1 filt_vld = 1'b0;
    cap = cyc;
    if (push) begin
      e.l = el; e.r = er; e.cap = cap;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("wait_idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    int bcnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_lft", int'(lft_out), 0);
    chk("rst_rht", int'(rht_out), 0);
    chk("rst_vld", int'(out_vld), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_amp", int'(AMP_ON), 0);

    // Unity gain, with busy-duration count
    send(pk(100, 200, 300, 400, 500), pk(-100, -200, -300, -400, -500),
         1024, 1024, 1024, 1024, 1024, 1024, 1, 1500, -1500);
    bcnt = 0;
    repeat (16) begin @(negedge clk); bcnt += int'(busy); end
    chk("busy_cycles", bcnt, 13);
    wait_idle();
    chk("amp_after_first", int'(AMP_ON), 1);

    // Mute
    send(pk(100, 200, 300, 400, 500), pk(-100, -200, -300, -400, -500),
         1024, 1024, 1024, 1024, 1024, 0, 1, 0, 0);
    wait_idle();

    // Saturation
    send(pk(30000, 30000, 30000, 30000, 30000), pk(-30000, -30000, -30000, -30000, -30000),
         1024, 1024, 1024, 1024, 1024, 1024, 1, 32767, -32768);
    wait_idle();

    // Per-band gain with clamp and floor rounding
    send(pk(20000, 1000, 1000, 1000, 1000), pk(-3, 1000, 1000, 1000, 1000),
         2048, 0, 0, 0, 0, 512, 1, 16383, -3);
    wait_idle();

    // Arithmetic shift floors toward minus infinity: -1*1>>>10 = -1, 1*1>>>10 = 0
    send(pk(-1, 0, 0, 0, 0), pk(1, 0, 0, 0, 0), 1, 0, 0, 0, 0, 1024, 1, -1, 0);
    wait_idle();
    chk("ovr_clear_before", int'(overrun), 0);

    // Overrun and input isolation
    send(pk(100, 200, 300, 400, 500), pk(-100, -200, -300, -400, -500),
         1024, 1024, 1024, 1024, 1024, 1024, 1, 1500, -1500);
    repeat (4) @(negedge clk);
    band_L = pk(7, 7, 7, 7, 7); band_R = pk(9, 9, 9, 9, 9); POT_VOL = 12'd0;
    filt_vld = 1'b1;
    @(posedge clk);
    #1 filt_vld = 1'b0;
    @(negedge clk);
    chk("ovr_set", int'(overrun), 1);
    wait_idle();
    send(pk(10, 0, 0, 0, 0), pk(-20, 0, 0, 0, 0), 1024, 0, 0, 0, 0, 1024, 1, 10, -20);
    wait_idle();
    chk("ovr_sticky", int'(overrun), 1);

    // Reset mid-sequence (BAND idx 6)
    send(pk(100, 200, 300, 400, 500), pk(-100, -200, -300, -400, -500),
         1024, 1024, 1024, 1024, 1024, 1024, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_lft", int'(lft_out), 0);
    chk("mid_rst_rht", int'(rht_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    repeat (16) @(negedge clk);
    chk("mid_rst_amp", int'(AMP_ON), 0);

    send(pk(100, 200, 300, 400, 500), pk(-100, -200, -300, -400, -500),
         1024, 1024, 1024, 1024, 1024, 1024, 1, 1500, -1500);
    wait_idle();
    chk("amp_on_after_rst", int'(AMP_ON), 1);
    while (cyc < cap + 31) @(negedge clk);
    chk("amp_at_31", int'(AMP_ON), 1);
    @(negedge clk);
    chk("amp_at_32", int'(AMP_ON), 0);
    repeat (5) @(negedge clk);
    chk("amp_stays_off", int'(AMP_ON), 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
